// File: rtl/instr_encoder.sv
// instr_encoder: packs register fields and a 32-bit immediate into a RISC-V
// I/S/B/J instruction word, selected by the same 2-bit immSrc code that the
// decode stage uses. Range and alignment are checked against the chosen
// format. Each emitted word is tagged with a sequential byte address.
// One registered stage with valid/ready handshakes on both sides.
module instr_encoder #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        immSrc,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] addr_out,
  output logic              range_err,
  output logic              align_err,
  output logic [CNT_W-1:0]  err_count
);

  // Immediate formats, matching the decode stage's immSrc encoding.
  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_S = 2'b01,
    FMT_B = 2'b10,
    FMT_J = 2'b11
  } immFmtE;

  immFmtE            immFmt;
  logic              accept;

  logic [31:0]       encWord;
  logic              encRangeErr;
  logic              encAlignErr;

  logic [ADDR_W-1:0] baseAligned;
  logic [ADDR_W-1:0] curAddr;

  logic              outValid_q, outValid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addrOut_q, addrOut_d;
  logic              rangeErr_q, rangeErr_d;
  logic              alignErr_q, alignErr_d;
  logic [CNT_W-1:0]  errCount_q, errCount_d;
  logic [ADDR_W-1:0] addrCnt_q, addrCnt_d;

  assign immFmt = immFmtE'(immSrc);

  // The stage is free when nothing is held or the held word leaves this cycle.
  assign in_ready = !outValid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Masking rather than slicing keeps every base_addr bit in use; the low two
  // bits are dropped so addresses stay word aligned.
  assign baseAligned = base_addr & ~ADDR_W'(3);

  // A base load in the same cycle as an accept applies to that very word.
  assign curAddr = load_base ? baseAligned : addrCnt_q;

  // Bit-scatter the immediate into the selected format and check that the
  // full 32-bit value survives the truncation (and alignment for branches).
  always_comb begin
    encWord     = 32'h0;
    encRangeErr = 1'b0;
    encAlignErr = 1'b0;
    case (immFmt)
      FMT_I: begin
        encWord     = {imm[11:0], rs1, funct3, rd, opcode};
        encRangeErr = (imm != {{20{imm[11]}}, imm[11:0]});
      end
      FMT_S: begin
        encWord     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        encRangeErr = (imm != {{20{imm[11]}}, imm[11:0]});
      end
      FMT_B: begin
        encWord     = {imm[12], imm[10:5], rs2, rs1, funct3,
                       imm[4:1], imm[11], opcode};
        encRangeErr = (imm != {{19{imm[12]}}, imm[12:0]});
        encAlignErr = imm[0];
      end
      FMT_J: begin
        encWord     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        encRangeErr = (imm != {{11{imm[20]}}, imm[20:0]});
        encAlignErr = imm[0];
      end
      default: begin
        encWord     = 32'h0;
        encRangeErr = 1'b0;
        encAlignErr = 1'b0;
      end
    endcase
  end

  // Next-state for the output register, address counter and error counter.
  always_comb begin
    outValid_d = outValid_q;
    instr_d    = instr_q;
    addrOut_d  = addrOut_q;
    rangeErr_d = rangeErr_q;
    alignErr_d = alignErr_q;
    errCount_d = errCount_q;
    addrCnt_d  = addrCnt_q;

    if (accept) begin
      outValid_d = 1'b1;
      instr_d    = encWord;
      addrOut_d  = curAddr;
      rangeErr_d = encRangeErr;
      alignErr_d = encAlignErr;
      addrCnt_d  = curAddr + ADDR_W'(4);
      if ((encRangeErr || encAlignErr) && (errCount_q != {CNT_W{1'b1}})) begin
        errCount_d = errCount_q + CNT_W'(1);
      end
    end else begin
      if (out_ready) begin
        outValid_d = 1'b0;
      end
      if (load_base) begin
        addrCnt_d = baseAligned;
      end
    end
  end

  // State register; reset drops any held word and restarts addressing at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      outValid_q <= 1'b0;
      instr_q    <= 32'h0;
      addrOut_q  <= '0;
      rangeErr_q <= 1'b0;
      alignErr_q <= 1'b0;
      errCount_q <= '0;
      addrCnt_q  <= '0;
    end else begin
      outValid_q <= outValid_d;
      instr_q    <= instr_d;
      addrOut_q  <= addrOut_d;
      rangeErr_q <= rangeErr_d;
      alignErr_q <= alignErr_d;
      errCount_q <= errCount_d;
      addrCnt_q  <= addrCnt_d;
    end
  end

  assign out_valid = outValid_q;
  assign instr     = instr_q;
  assign addr_out  = addrOut_q;
  assign range_err = rangeErr_q;
  assign align_err = alignErr_q;
  assign err_count = errCount_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder.
module tb_instr_encoder;

  logic        clk;
  logic        reset;
  logic        load_base;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  immSrc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] addr_out;
  logic        range_err;
  logic        align_err;
  logic [7:0]  err_count;

  int testsRun;
  int testsFailed;

  instr_encoder #(.ADDR_W(32), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_base (load_base),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .immSrc    (immSrc),
    .opcode    (opcode),
    .funct3    (funct3),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .addr_out  (addr_out),
    .range_err (range_err),
    .align_err (align_err),
    .err_count (err_count)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word on the input side.
  task automatic driveWord(input logic [1:0] src, input logic [6:0] op,
                           input logic [2:0] f3, input logic [4:0] rdV,
                           input logic [4:0] rs1V, input logic [4:0] rs2V,
                           input logic [31:0] immV);
    in_valid = 1'b1;
    immSrc   = src;
    opcode   = op;
    funct3   = f3;
    rd       = rdV;
    rs1      = rs1V;
    rs2      = rs2V;
    imm      = immV;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    load_base = 1'b0;
    base_addr = 32'h0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    immSrc    = 2'b00;
    opcode    = 7'h0;
    funct3    = 3'h0;
    rd        = 5'h0;
    rs1       = 5'h0;
    rs2       = 5'h0;
    imm       = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
    testsRun++; if (instr !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_instr got %h want 00000000", instr); end
    testsRun++; if (addr_out !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_addr got %h want 00000000", addr_out); end
    testsRun++; if ({range_err, align_err} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_errs got %b want 00", {range_err, align_err}); end
    testsRun++; if (err_count !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_err_count got %0d want 0", err_count); end
    testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_encode();
    load_base = 1'b1;
    base_addr = 32'h0000_0100;
    tick();
    load_base = 1'b0;
    driveWord(2'b00, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    tick();
    testsRun++; if (instr !== 32'hFFF0_0093) begin testsFailed++; $display("[TB] FAIL enc_I got %h want FFF00093", instr); end
    testsRun++; if (addr_out !== 32'h100) begin testsFailed++; $display("[TB] FAIL enc_I_addr got %h want 00000100", addr_out); end
    testsRun++; if ({out_valid, range_err, align_err} !== 3'b100) begin testsFailed++; $display("[TB] FAIL enc_I_flags got %b want 100", {out_valid, range_err, align_err}); end
    driveWord(2'b01, 7'h23, 3'd2, 5'd0, 5'd3, 5'd2, 32'd8);
    tick();
    testsRun++; if (instr !== 32'h0021_A423) begin testsFailed++; $display("[TB] FAIL enc_S got %h want 0021A423", instr); end
    testsRun++; if (addr_out !== 32'h104) begin testsFailed++; $display("[TB] FAIL enc_S_addr got %h want 00000104", addr_out); end
    driveWord(2'b10, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    tick();
    testsRun++; if (instr !== 32'hFE00_0EE3) begin testsFailed++; $display("[TB] FAIL enc_B got %h want FE000EE3", instr); end
    testsRun++; if (addr_out !== 32'h108) begin testsFailed++; $display("[TB] FAIL enc_B_addr got %h want 00000108", addr_out); end
    testsRun++; if ({range_err, align_err} !== 2'b00) begin testsFailed++; $display("[TB] FAIL enc_B_errs got %b want 00", {range_err, align_err}); end
    driveWord(2'b11, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
    tick();
    testsRun++; if (instr !== 32'h0010_00EF) begin testsFailed++; $display("[TB] FAIL enc_J got %h want 001000EF", instr); end
    testsRun++; if (addr_out !== 32'h10C) begin testsFailed++; $display("[TB] FAIL enc_J_addr got %h want 0000010C", addr_out); end
    in_valid = 1'b0;
    tick();
    testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL enc_drain_valid got %0b want 0", out_valid); end
    testsRun++; if (err_count !== 8'd0) begin testsFailed++; $display("[TB] FAIL enc_err_count got %0d want 0", err_count); end
  endtask

  task automatic test_errors();
    driveWord(2'b00, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    tick();
    testsRun++; if (instr !== 32'h8000_0093) begin testsFailed++; $display("[TB] FAIL errI_instr got %h want 80000093", instr); end
    testsRun++; if ({range_err, align_err} !== 2'b10) begin testsFailed++; $display("[TB] FAIL errI_flags got %b want 10", {range_err, align_err}); end
    testsRun++; if (addr_out !== 32'h110) begin testsFailed++; $display("[TB] FAIL errI_addr got %h want 00000110", addr_out); end
    driveWord(2'b10, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'd3);
    tick();
    testsRun++; if (instr !== 32'h0000_0163) begin testsFailed++; $display("[TB] FAIL errB_instr got %h want 00000163", instr); end
    testsRun++; if ({range_err, align_err} !== 2'b01) begin testsFailed++; $display("[TB] FAIL errB_flags got %b want 01", {range_err, align_err}); end
    driveWord(2'b11, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0010_0000);
    tick();
    testsRun++; if (instr !== 32'h8000_006F) begin testsFailed++; $display("[TB] FAIL errJ_instr got %h want 8000006F", instr); end
    testsRun++; if ({range_err, align_err} !== 2'b10) begin testsFailed++; $display("[TB] FAIL errJ_flags got %b want 10", {range_err, align_err}); end
    testsRun++; if (err_count !== 8'd3) begin testsFailed++; $display("[TB] FAIL errJ_count got %0d want 3", err_count); end
    // -2048 is the most negative legal I immediate.
    driveWord(2'b00, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);
    tick();
    testsRun++; if (instr !== 32'h8000_0093) begin testsFailed++; $display("[TB] FAIL edgeI_instr got %h want 80000093", instr); end
    testsRun++; if ({range_err, align_err} !== 2'b00) begin testsFailed++; $display("[TB] FAIL edgeI_flags got %b want 00", {range_err, align_err}); end
    // 4096 is one past the largest B offset.
    driveWord(2'b10, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'd4096);
    tick();
    testsRun++; if (instr !== 32'h8000_0063) begin testsFailed++; $display("[TB] FAIL edgeB_instr got %h want 80000063", instr); end
    testsRun++; if ({range_err, align_err} !== 2'b10) begin testsFailed++; $display("[TB] FAIL edgeB_flags got %b want 10", {range_err, align_err}); end
    testsRun++; if (err_count !== 8'd4) begin testsFailed++; $display("[TB] FAIL edgeB_count got %0d want 4", err_count); end
    // 252 more errored words bring the total to 256, one past saturation.
    driveWord(2'b11, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0010_0000);
    for (int i = 0; i < 252; i++) tick();
    in_valid = 1'b0;
    tick();
    testsRun++; if (err_count !== 8'd255) begin testsFailed++; $display("[TB] FAIL err_saturate got %0d want 255", err_count); end
  endtask

  task automatic test_backpressure();
    load_base = 1'b1;
    base_addr = 32'h0000_0300;
    tick();
    load_base = 1'b0;
    driveWord(2'b00, 7'h13, 3'd0, 5'd2, 5'd0, 5'd0, 32'd1);
    tick();
    testsRun++; if (instr !== 32'h0010_0113) begin testsFailed++; $display("[TB] FAIL bp_w0 got %h want 00100113", instr); end
    out_ready = 1'b0;
    driveWord(2'b00, 7'h13, 3'd0, 5'd2, 5'd0, 5'd0, 32'd2);
    #1;
    for (int i = 0; i < 3; i++) begin
      testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_in_ready[%0d] got %0b want 0", i, in_ready); end
      tick();
      testsRun++; if ({out_valid, instr, addr_out} !== {1'b1, 32'h0010_0113, 32'h300}) begin testsFailed++; $display("[TB] FAIL bp_hold[%0d] got v=%0b %h @%h want v=1 00100113 @00000300", i, out_valid, instr, addr_out); end
    end
    out_ready = 1'b1;
    #1;
    testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_release_ready got %0b want 1", in_ready); end
    tick();
    testsRun++; if ({instr, addr_out} !== {32'h0020_0113, 32'h304}) begin testsFailed++; $display("[TB] FAIL bp_w1 got %h @%h want 00200113 @00000304", instr, addr_out); end
    driveWord(2'b00, 7'h13, 3'd0, 5'd2, 5'd0, 5'd0, 32'd3);
    tick();
    testsRun++; if ({instr, addr_out} !== {32'h0030_0113, 32'h308}) begin testsFailed++; $display("[TB] FAIL bp_w2 got %h @%h want 00300113 @00000308", instr, addr_out); end
    in_valid = 1'b0;
    tick();
    testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_load_base();
    load_base = 1'b1;
    base_addr = 32'h0000_0203;
    driveWord(2'b00, 7'h13, 3'd0, 5'd2, 5'd0, 5'd0, 32'd5);
    tick();
    load_base = 1'b0;
    testsRun++; if ({instr, addr_out} !== {32'h0050_0113, 32'h200}) begin testsFailed++; $display("[TB] FAIL lb_same_cycle got %h @%h want 00500113 @00000200", instr, addr_out); end
    driveWord(2'b00, 7'h13, 3'd0, 5'd2, 5'd0, 5'd0, 32'd6);
    tick();
    testsRun++; if (addr_out !== 32'h204) begin testsFailed++; $display("[TB] FAIL lb_next got %h want 00000204", addr_out); end
    // A base load while a word is held must not retag that word.
    out_ready = 1'b0;
    in_valid  = 1'b0;
    load_base = 1'b1;
    base_addr = 32'h0000_0400;
    tick();
    load_base = 1'b0;
    testsRun++; if ({out_valid, addr_out} !== {1'b1, 32'h204}) begin testsFailed++; $display("[TB] FAIL lb_held got v=%0b @%h want v=1 @00000204", out_valid, addr_out); end
    out_ready = 1'b1;
    driveWord(2'b00, 7'h13, 3'd0, 5'd2, 5'd0, 5'd0, 32'd7);
    tick();
    testsRun++; if (addr_out !== 32'h400) begin testsFailed++; $display("[TB] FAIL lb_after_held got %h want 00000400", addr_out); end
    load_base = 1'b1;
    base_addr = 32'hFFFF_FFFC;
    driveWord(2'b00, 7'h13, 3'd0, 5'd2, 5'd0, 5'd0, 32'd8);
    tick();
    load_base = 1'b0;
    testsRun++; if (addr_out !== 32'hFFFF_FFFC) begin testsFailed++; $display("[TB] FAIL lb_top got %h want FFFFFFFC", addr_out); end
    driveWord(2'b00, 7'h13, 3'd0, 5'd2, 5'd0, 5'd0, 32'd9);
    tick();
    testsRun++; if ({instr, addr_out} !== {32'h0090_0113, 32'h0}) begin testsFailed++; $display("[TB] FAIL lb_wrap got %h @%h want 00900113 @00000000", instr, addr_out); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midtransfer();
    driveWord(2'b00, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    testsRun++; if ({out_valid, range_err} !== 2'b11) begin testsFailed++; $display("[TB] FAIL rst_pre got %b want 11", {out_valid, range_err}); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_mid_valid got %0b want 0", out_valid); end
    testsRun++; if (err_count !== 8'd0) begin testsFailed++; $display("[TB] FAIL rst_mid_count got %0d want 0", err_count); end
    testsRun++; if ({instr, range_err} !== {32'h0, 1'b0}) begin testsFailed++; $display("[TB] FAIL rst_mid_out got %h re=%0b want 00000000 re=0", instr, range_err); end
    out_ready = 1'b1;
    driveWord(2'b00, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    tick();
    testsRun++; if ({out_valid, instr, addr_out} !== {1'b1, 32'h0010_0093, 32'h0}) begin testsFailed++; $display("[TB] FAIL rst_next got v=%0b %h @%h want v=1 00100093 @00000000", out_valid, instr, addr_out); end
    in_valid = 1'b0;
    tick();
  endtask

  // Run every scenario in order, then report.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    test_reset();
    test_encode();
    test_errors();
    test_backpressure();
    test_load_base();
    test_reset_midtransfer();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
